// File: rtl/hazard_trap_sequencer.sv
// Pipeline hazard, trap and mret sequencer for the two-stage core.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_trap_sequencer (
  input  logic        CLK,
  input  logic        RST,
  input  logic        i_mem_busy,
  input  logic        d_mem_busy,
  input  logic        dren,
  input  logic        dwen,
  input  logic        jump,
  input  logic        branch,
  input  logic        mispredict,
  input  logic        halt,
  input  logic        ret,
  input  logic        token_ex,
  input  logic        mal_insn,
  input  logic        fault_insn,
  input  logic        breakpoint,
  input  logic        illegal_insn,
  input  logic        env_m,
  input  logic        mal_l,
  input  logic        fault_l,
  input  logic        mal_s,
  input  logic        fault_s,
  input  logic [31:0] epc_f,
  input  logic [31:0] epc_e,
  input  logic [31:0] badaddr_f,
  input  logic [31:0] badaddr_e,
  input  logic [31:0] tvec,
  input  logic [31:0] mepc,
  output logic        pc_en,
  output logic        npc_sel,
  output logic        if_ex_stall,
  output logic        if_ex_flush,
  output logic        iren,
  output logic [31:0] priv_pc,
  output logic        insert_priv_pc,
  output logic        trap_valid,
  output logic        mret_valid,
  output logic [3:0]  trap_cause,
  output logic [31:0] trap_epc,
  output logic [31:0] trap_badaddr,
  output logic        halted,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
);

  // state    | meaning
  // RUN      | normal flow, hazard stalls and branch flushes
  // DRAIN    | event captured, waiting for data memory to go idle
  // TRAP     | one-cycle trap_valid / mret_valid strobe
  // REDIRECT | fetch redirected to tvec or mepc
  // HALTED   | core stopped until reset
  typedef enum logic [2:0] {RUN, DRAIN, TRAP, REDIRECT, HALTED} state_t;

  state_t state, state_nxt;

  logic       ev;
  logic       ev_fetch;
  logic       ev_ret;
  logic [3:0] ev_cause;
  logic       is_ret;

  // branch is resolved upstream into jump/mispredict; kept for port compatibility
  logic unused_branch;
  assign unused_branch = branch;

  always_comb begin
    ev       = 1'b1;
    ev_fetch = 1'b0;
    ev_ret   = 1'b0;
    ev_cause = 4'd0;
    if (token_ex && breakpoint)        ev_cause = 4'd3;
    else if (token_ex && illegal_insn) ev_cause = 4'd2;
    else if (token_ex && env_m)        ev_cause = 4'd11;
    else if (token_ex && mal_l)        ev_cause = 4'd4;
    else if (token_ex && fault_l)      ev_cause = 4'd5;
    else if (token_ex && mal_s)        ev_cause = 4'd6;
    else if (token_ex && fault_s)      ev_cause = 4'd7;
    else if (token_ex && ret)          ev_ret   = 1'b1;
    else if (!i_mem_busy && mal_insn) begin
      ev_cause = 4'd0;
      ev_fetch = 1'b1;
    end else if (!i_mem_busy && fault_insn) begin
      ev_cause = 4'd1;
      ev_fetch = 1'b1;
    end else begin
      ev = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= RUN;
    else     state <= state_nxt;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      trap_cause   <= 4'd0;
      trap_epc     <= 32'd0;
      trap_badaddr <= 32'd0;
      is_ret       <= 1'b0;
    end else if (state == RUN && ev) begin
      trap_cause   <= ev_cause;
      trap_epc     <= ev_fetch ? epc_f : epc_e;
      trap_badaddr <= ev_fetch ? badaddr_f : badaddr_e;
      is_ret       <= ev_ret;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (ev)                    state_nxt = d_mem_busy ? DRAIN : TRAP;
        else if (halt && token_ex) state_nxt = HALTED;
      end
      DRAIN:    if (!d_mem_busy) state_nxt = TRAP;
      TRAP:     state_nxt = REDIRECT;
      REDIRECT: state_nxt = RUN;
      HALTED:   state_nxt = HALTED;
      default:  state_nxt = RUN;
    endcase
  end

  // Outputs are gated by RST so the reset values hold for the whole reset window.
  always_comb begin
    pc_en          = 1'b0;
    npc_sel        = 1'b0;
    if_ex_stall    = 1'b1;
    if_ex_flush    = 1'b0;
    iren           = 1'b1;
    priv_pc        = 32'd0;
    insert_priv_pc = 1'b0;
    trap_valid     = 1'b0;
    mret_valid     = 1'b0;
    halted         = 1'b0;
    if (RST) begin
      iren = 1'b0;
    end else begin
      case (state)
        RUN: begin
          if_ex_stall = i_mem_busy | (d_mem_busy & (dren | dwen)) | ev;
          pc_en       = ~if_ex_stall;
          npc_sel     = jump | mispredict;
          if_ex_flush = npc_sel;
        end
        TRAP: begin
          trap_valid = ~is_ret;
          mret_valid = is_ret;
        end
        REDIRECT: begin
          insert_priv_pc = 1'b1;
          priv_pc        = is_ret ? mepc : tvec;
          pc_en          = 1'b1;
          if_ex_flush    = 1'b1;
          if_ex_stall    = 1'b0;
        end
        HALTED: begin
          iren   = 1'b0;
          halted = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_count <= 32'd0;
      flush_count <= 32'd0;
    end else begin
      if (if_ex_stall) stall_count <= stall_count + 32'd1;
      if (if_ex_flush) flush_count <= flush_count + 32'd1;
    end
  end
`else
  assign stall_count = 32'd0;
  assign flush_count = 32'd0;
`endif

endmodule
